// File: rtl/envshape_pkg.sv
// Shared types and constants for the envelope shaper: FSM states, saturation
// bounds, DAC midscale and the dither LFSR definition.
package envshape_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_e;

  localparam int unsigned SAT_W = 16;

  localparam logic [11:0]             MIDSCALE = 12'd2048;
  localparam logic signed [SAT_W-1:0] SAT_MAX  = 16'sh7FFF;
  localparam logic signed [SAT_W-1:0] SAT_MIN  = 16'sh8000;

  // Fibonacci x^16+x^14+x^13+x^11+1, shifting right: taps land on bits 0,2,3,5
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: counts 0..DIV-1 and raises tick_o for the single cycle
// in which the count sits at DIV-1.
module sample_tick_gen #(
  parameter int unsigned DIV = 1041
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
  end

  // tick is registered from the next count so it lines up with cnt_q == DIV-1
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CNT_LAST);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/envelope_shaper.sv
// Decimates the tone stream to SAMPLE_HZ, applies an attack/sustain/release gain
// and delivers 12-bit offset-binary DAC codes. Define ENVSHAPE_DITHER_EN for LFSR dither.
module envelope_shaper
  import envshape_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned SAMPLE_HZ    = 48_000,
  parameter int unsigned IN_W         = 32,
  parameter int unsigned OUT_W        = 12,
  parameter int unsigned ENV_W        = 8,
  parameter int unsigned ATTACK_STEP  = 5,
  parameter int unsigned RELEASE_STEP = 1
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   play,
  input  logic                   step,
  input  logic signed [IN_W-1:0] sample_in,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ENV_W-1:0]       env_level,
  output logic                   busy,
  output logic                   overrun
);

  localparam int unsigned DIV    = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned ENV_W1 = ENV_W + 1;
  localparam int unsigned PROD_W = SAT_W + ENV_W + 1;
  localparam int unsigned SCL_W  = PROD_W - ENV_W;
  localparam int unsigned SHIFT  = SAT_W - OUT_W;
  localparam logic [ENV_W-1:0] ENV_MAX = {ENV_W{1'b1}};

  logic tick;

  sample_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .tick_o (tick)
  );

  // ---------------------------------------------------------------- envelope
  env_state_e       state_q, state_d;
  logic [ENV_W-1:0] env_q, env_d;
  logic             step_q, step_d;
  logic             busy_q;
  logic [ENV_W:0]   env_sum;
  logic [ENV_W-1:0] env_up, env_dn;
  logic             step_hit;

  always_comb begin
    env_sum  = {1'b0, env_q} + ENV_W1'(ATTACK_STEP);
    env_up   = (env_sum > {1'b0, ENV_MAX}) ? ENV_MAX : env_sum[ENV_W-1:0];
    env_dn   = (env_q > ENV_W'(RELEASE_STEP)) ? (env_q - ENV_W'(RELEASE_STEP)) : '0;
    // a step arriving in the tick cycle itself counts as latched
    step_hit = step_q | step;
  end

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    step_d  = step_q | step;
    if (tick) begin
      step_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          env_d = '0;
          if (play) state_d = ATTACK;
        end
        ATTACK: begin
          if (!play) begin
            state_d = RELEASE;
          end else begin
            env_d = env_up;
            if (env_up == ENV_MAX) state_d = SUSTAIN;
          end
        end
        SUSTAIN: begin
          if (!play)         state_d = RELEASE;
          else if (step_hit) state_d = ATTACK;
        end
        RELEASE: begin
          if (play && step_hit) begin
            state_d = ATTACK;
          end else begin
            env_d = env_dn;
            if (env_dn == '0) state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          env_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      env_q   <= '0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      step_q  <= step_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // ---------------------------------------------------------------- datapath
  logic signed [SAT_W-1:0]  sat_c, sat_q;
  logic                     s1_vld_q;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [SCL_W-1:0]  scaled_c, shaped_c;
  logic [OUT_W-1:0]         code_c;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overrun_q, overrun_d;

  always_comb begin
    if (sample_in > IN_W'(SAT_MAX))      sat_c = SAT_MAX;
    else if (sample_in < IN_W'(SAT_MIN)) sat_c = SAT_MIN;
    else                                 sat_c = SAT_W'(sample_in);
  end

`ifdef ENVSHAPE_DITHER_EN
  localparam int unsigned SCL_W1 = SCL_W + 1;

  logic [15:0]              lfsr_q;
  logic signed [SCL_W1-1:0] dith_c;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)     lfsr_q <= LFSR_SEED;
    else if (tick) lfsr_q <= lfsr_next(lfsr_q);
  end
`endif

  always_comb begin
    prod_c   = PROD_W'(sat_q) * PROD_W'($signed({1'b0, env_q}));
    scaled_c = SCL_W'(prod_c >>> ENV_W);
`ifdef ENVSHAPE_DITHER_EN
    dith_c = SCL_W1'(scaled_c) + SCL_W1'(lfsr_q[3:0]);
    if (dith_c > SCL_W1'(SAT_MAX)) dith_c = SCL_W1'(SAT_MAX);
    shaped_c = SCL_W'(dith_c);
`else
    shaped_c = scaled_c;
`endif
    code_c = OUT_W'(shaped_c >>> SHIFT) + OUT_W'(MIDSCALE);
  end

  // a fresh code always wins; overwriting an undelivered one is flagged sticky
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (s1_vld_q) begin
      out_data_d  = code_c;
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) overrun_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sat_q       <= '0;
      s1_vld_q    <= 1'b0;
      out_data_q  <= OUT_W'(MIDSCALE);
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (tick) sat_q <= sat_c;
      s1_vld_q    <= tick;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign env_level = env_q;
  assign busy      = busy_q;

endmodule
